// File: rtl/fpcvt_pkg.sv
// Shared constants and FSM encoding for the 8-bit float <-> 12-bit linear converters.
// The encoder and decoder both import this so the format is defined in one place.
package fpcvt_pkg;

  localparam int EXP_W = 3;
  localparam int MAN_W = 4;
  localparam int OUT_W = 12;

  // Largest decodable magnitude: all-ones mantissa at the largest exponent (15 << 7).
  localparam int MAX_MAG = ((1 << MAN_W) - 1) << ((1 << EXP_W) - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    SIGN  = 2'd2,
    HOLD  = 2'd3
  } state_t;

endpackage

// File: rtl/fp_to_linear.sv
// Decodes {S, E, F} to D = (-1)^S * F * 2^E as a two's-complement word,
// shifting the mantissa one place per clock.
import fpcvt_pkg::*;

module fp_to_linear #(
  parameter int EXP_W_P = EXP_W,
  parameter int MAN_W_P = MAN_W,
  parameter int OUT_W_P = OUT_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               S,
  input  logic [EXP_W_P-1:0] E,
  input  logic [MAN_W_P-1:0] F,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [OUT_W_P-1:0] D,
  output state_t             fsm_state
);

  // Handshake: a transfer happens on a rising edge where valid and ready are both high;
  // the source holds its data and valid until then, and the sink may drop ready at will.

  state_t               state;
  logic                 sign_q;
  logic [OUT_W_P-2:0]   mag;
  logic [EXP_W_P-1:0]   cnt;

  assign in_ready  = (state == IDLE) && !rst;
  assign fsm_state = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      sign_q    <= 1'b0;
      mag       <= '0;
      cnt       <= '0;
      D         <= '0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          // S/E/F are only looked at here, so X on them elsewhere never reaches state.
          if (in_valid) begin
            sign_q <= S;
            mag    <= {{(OUT_W_P-1-MAN_W_P){1'b0}}, F};
            cnt    <= E;
            state  <= SHIFT;
          end
        end
        SHIFT: begin
          if (cnt != '0) begin
            mag <= mag << 1;
            cnt <= cnt - 1'b1;
          end else begin
            state <= SIGN;
          end
        end
        SIGN: begin
          // Negating a zero magnitude gives zero, so -0 never appears as a code.
          D         <= sign_q ? -{1'b0, mag} : {1'b0, mag};
          out_valid <= 1'b1;
          state     <= HOLD;
        end
        HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_to_linear.sv
// Self-checking bench for fp_to_linear: directed cases plus randomized traffic
// checked against an arithmetic model with a scoreboard of expected results.
import fpcvt_pkg::*;

module tb_fp_to_linear;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic             S = 1'b0;
  logic [EXP_W-1:0] E = '0;
  logic [MAN_W-1:0] F = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [OUT_W-1:0] D;
  state_t           fsm_state;

  fp_to_linear dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .S         (S),
    .E         (E),
    .F         (F),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .D         (D),
    .fsm_state (fsm_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference: plain integer arithmetic, truncated to the output width.
  function automatic logic [OUT_W-1:0] model_d(input bit s, input int e, input int f);
    int v;
    v = f * (1 << e);
    if (s) v = -v;
    return v[OUT_W-1:0];
  endfunction

  // ---------------- scoreboard / monitor ----------------
  logic [OUT_W-1:0] exp_q[$];
  int               lat_q[$];
  int               acc_q[$];
  bit               busy = 1'b0;
  bit               prev_ov = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      lat_q.delete();
      acc_q.delete();
      busy    = 1'b0;
      prev_ov = 1'b0;
    end else begin
      check("in_ready", {31'd0, in_ready}, {31'd0, !busy});
      if (out_valid && !prev_ov) begin
        if (acc_q.size() == 0) check("spurious_ov", {31'd0, out_valid}, 32'd0);
        else check("latency", cyc - acc_q.pop_front(), lat_q.pop_front());
      end
      if (out_valid && exp_q.size() != 0) check("d_value", {20'd0, D}, {20'd0, exp_q[0]});
      if (out_valid && out_ready && exp_q.size() != 0) begin
        void'(exp_q.pop_front());
        busy = 1'b0;
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(model_d(S, int'(E), int'(F)));
        lat_q.push_back(int'(E) + 2);
        acc_q.push_back(cyc + 1);
        busy = 1'b1;
      end
      prev_ov = out_valid;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_accept(output int acc);
    int n;
    n   = 0;
    acc = -1;
    while (acc < 0 && n < 60) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk);
        #1;
        acc      = cyc;
        in_valid = 1'b0;
        S        = 1'($urandom);
        E        = EXP_W'($urandom);
        F        = MAN_W'($urandom);
      end
      n++;
    end
    if (acc < 0) begin
      check("accept_timeout", {31'd0, in_ready}, 32'd1);
      in_valid = 1'b0;
    end
  endtask

  task automatic send(input bit s, input int e, input int f, output int acc);
    in_valid = 1'b1;
    S        = s;
    E        = EXP_W'(e);
    F        = MAN_W'(f);
    wait_accept(acc);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((busy || exp_q.size() != 0) && n < 100) begin
      @(posedge clk);
      n++;
    end
    if (n >= 100) check("drain_timeout", {31'd0, busy}, 32'd0);
    @(posedge clk);
    #1;
  endtask

  // ---------------- stimulus ----------------
  int a0, a1;

  initial begin
    // Reset state
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_d", {20'd0, D}, 32'd0);
    check("rst_ov", {31'd0, out_valid}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd0);
    check("rst_state", {30'd0, fsm_state}, {30'd0, IDLE});
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("idle_in_ready", {31'd0, in_ready}, 32'd1);

    // Basic shift: 12 << 5 = 384
    out_ready = 1'b1;
    send(1'b0, 5, 12, a0);
    drain();
    check("basic_d", {20'd0, D}, 32'd384);

    // Maximum negative: -(15 << 7)
    send(1'b1, 7, 15, a0);
    drain();
    check("maxneg_d", {20'd0, D}, 32'h880);

    // Zero exponent
    send(1'b0, 0, 5, a0);
    drain();
    check("e0_d", {20'd0, D}, 32'd5);
    send(1'b1, 0, 0, a0);
    drain();
    check("neg_zero_d", {20'd0, D}, 32'd0);

    // Backpressure with a second input held throughout the stall
    out_ready = 1'b0;
    send(1'b0, 2, 1, a0);
    in_valid = 1'b1;
    S = 1'b0;
    E = 3'd1;
    F = 4'd3;
    repeat (14) @(posedge clk);
    #1;
    check("bp_d_stall", {20'd0, D}, 32'd4);
    check("bp_ov_stall", {31'd0, out_valid}, 32'd1);
    check("bp_in_ready", {31'd0, in_ready}, 32'd0);
    out_ready = 1'b1;
    wait_accept(a1);
    drain();
    check("bp_d_second", {20'd0, D}, 32'd6);

    // Reset mid-shift: a long conversion is aborted with no late output
    send(1'b0, 6, 9, a0);
    @(posedge clk);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_ov", {31'd0, out_valid}, 32'd0);
    check("mid_rst_d", {20'd0, D}, 32'd0);
    check("mid_rst_in_ready", {31'd0, in_ready}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
    repeat (12) @(posedge clk);
    #1;
    check("no_late_ov", {31'd0, out_valid}, 32'd0);

    // Back-to-back: 7 << 1 = 14, then -(3 << 2) = -12
    send(1'b0, 1, 7, a0);
    send(1'b1, 2, 3, a1);
    check("b2b_spacing", a1 - a0, 32'd5);
    drain();
    check("b2b_d", {20'd0, D}, 32'hFF4);

    // Randomized traffic with occasional backpressure
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 1) == 1) begin
        drain();
        out_ready = 1'b0;
        send(1'($urandom), $urandom_range(0, 7), $urandom_range(0, 15), a0);
        repeat ($urandom_range(0, 12)) @(posedge clk);
        #1;
        out_ready = 1'b1;
      end else begin
        out_ready = 1'b1;
        send(1'($urandom), $urandom_range(0, 7), $urandom_range(0, 15), a0);
      end
    end
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fp_to_linear.md
Name: fp_to_linear

Overview:
- Decoder for the team's 8-bit floating-point format {S, E[2:0], F[3:0]}. It is the inverse of the 12-bit linear-to-float converter.
- Value is reconstructed as D = (−1)^S · F · 2^E, output as a 12-bit two's-complement word.
- Multi-cycle: one mantissa shift per clock, with a valid/ready handshake on both sides.
- Sits downstream of the float encoder for round-trip checking and display paths.

Parameters:
- EXP_W, 3, exponent width.
- MAN_W, 4, mantissa width.
- OUT_W, 12, output width. Must satisfy OUT_W ≥ MAN_W + 2^EXP_W.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  S/E/F valid.
- in_ready  out  1  block can accept an input.
- S  in  1  sign.
- E  in  EXP_W  exponent.
- F  in  MAN_W  mantissa.
- out_valid  out  1  D holds a finished result.
- out_ready  in  1  consumer accepts D.
- D  out  OUT_W  two's-complement result.

Behaviour:
- One clock (clk). Reset is asynchronous and active-high (rst).
- While rst is high:
  - state is IDLE.
  - D = 0, out_valid = 0.
  - Internal magnitude and counter are 0.
  - in_ready = 0.
- After rst falls, in_ready = (state == IDLE).
- States: IDLE, SHIFT, SIGN, HOLD.
- IDLE:
  - Accept occurs on an edge where in_valid & in_ready.
  - On accept: latch S; mag ← zero-extended F (OUT_W−1 bits); cnt ← E; go to SHIFT.
  - S/E/F are ignored after the accepting edge.
- SHIFT:
  - If cnt ≠ 0: mag ← mag << 1, cnt ← cnt − 1.
  - If cnt = 0: go to SIGN.
  - No overflow is possible given the OUT_W constraint. Maximum is 15 << 7 = 1920.
- SIGN:
  - D ← S ? (−mag) : mag, in OUT_W-bit two's complement.
  - out_valid ← 1; go to HOLD.
  - S=1 with F=0 yields D=0, not a negative code.
- HOLD:
  - D and out_valid stay stable until out_valid & out_ready.
  - On that edge: out_valid ← 0, go to IDLE. D keeps its last value.
- Latency: out_valid rises E+2 edges after the accepting edge (range 2..9).
- Throughput, with out_ready held high: one result per E+4 cycles. New inputs are accepted only in IDLE; there is no overlap.
- in_valid presented outside IDLE is not consumed. The source must hold it.
- rst asserted mid-operation (any state):
  - Aborts immediately; D and out_valid clear asynchronously.
  - No partial result is ever emitted.
- S, E, F are unused while not in IDLE. X on them there must not propagate.

Decomposition:
- Shared package fpcvt_pkg:
  - EXP_W, MAN_W, OUT_W constants, also used by the encoder.
  - State encoding localparams (IDLE=0, SHIFT=1, SIGN=2, HOLD=3).
  - Max-magnitude constant (1920).
- No sub-module. The shifter/counter and negate stage are small enough to stay inline in fp_to_linear.

Test Plan:
- Basic shift:
  - Stimulus: S=0, E=3'b101, F=4'b1100, out_ready=1.
  - Required: D=12'b000110000000 (384), out_valid one cycle, 7 edges after accept. This is the round-trip of 368 through the encoder.
- Maximum negative:
  - Stimulus: S=1, E=3'b111, F=4'b1111.
  - Required: D=12'b100010000000 (−1920), latency 9.
- Zero-exponent cases:
  - Stimulus: S=0, E=0, F=4'b0101. Required: D=5, latency 2.
  - Stimulus: S=1, E=0, F=0. Required: D=12'b000000000000.
- Backpressure:
  - Stimulus: E=2, F=1, out_ready=0 for 10 cycles; a new in_valid with E=1, F=3 is held throughout.
  - Required during stall: D=4 and out_valid held; in_ready=0; second input not taken.
  - Required after out_ready=1: one handshake, then accept of the second input, then D=6.
- Reset mid-shift:
  - Stimulus: accept E=6, F=9; pulse rst on the 3rd cycle.
  - Required: out_valid=0 and D=0 asynchronously; in_ready=1 after release; no late output.
- Back-to-back:
  - Stimulus: in_valid held with E=1, F=7 then S=1, E=2, F=3; out_ready=1.
  - Required: D=14 then D=−12 (12'hFF4), in order, spaced E+4 cycles.
